// File: rtl/seq_alu_if.sv
// Operation request / register-file write-back bundle for seq_alu.
// The master issues operations; the slave (the ALU) returns the write-back strobe and result.
interface seq_alu_if #(
   parameter int W = 8,
   parameter int D = 4
);
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] acc_in;
   logic [W-1:0] reg_in;
   logic [D-1:0] dest_in;
   logic         busy;
   logic         done;
   logic         write_enabled;
   logic [D-1:0] reg_write_number;
   logic [W-1:0] reg_write_data;
   logic         carry_out;

   modport master (
      output start, op, acc_in, reg_in, dest_in,
      input  busy, done, write_enabled, reg_write_number, reg_write_data, carry_out
   );

   modport slave (
      input  start, op, acc_in, reg_in, dest_in,
      output busy, done, write_enabled, reg_write_number, reg_write_data, carry_out
   );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, bit-serial shifts and a shift-add multiplier.
// Results are written back through a one-cycle DONE strobe and held until the next DONE.
module seq_alu #(
   parameter int W = 8,
   parameter int D = 4
) (
   input  logic       clk,
   input  logic       reset,
   seq_alu_if.slave   bus
);
   localparam int CW = ($clog2(W + 1) > 3) ? $clog2(W + 1) : 3;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_SHL  = 3'b100;
   localparam logic [2:0] OP_SHR  = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;
   localparam logic [2:0] OP_MULH = 3'b111;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state_reg;
   logic [2:0]     op_reg;
   logic [D-1:0]   dest_reg;
   logic [W-1:0]   a_reg;
   logic [2*W-1:0] prod_reg;
   logic [CW-1:0]  cnt_reg;
   logic           busy_reg;
   logic           done_reg;
   logic           we_reg;
   logic [D-1:0]   wnum_reg;
   logic [W-1:0]   wdata_reg;
   logic           carry_reg;

   logic [W:0]     add_full;
   logic [W:0]     sub_full;
   logic           imm_op;
   logic [W-1:0]   imm_data;
   logic           imm_carry;
   logic [W-1:0]   shl_step;
   logic [W-1:0]   shr_step;
   logic [W:0]     mul_sum;
   logic [2*W-1:0] mul_next;

   // Single-cycle results, computed straight from the operand inputs on the start edge.
   always_comb begin
      add_full  = {1'b0, bus.acc_in} + {1'b0, bus.reg_in};
      sub_full  = {1'b0, bus.acc_in} - {1'b0, bus.reg_in};
      imm_op    = !bus.op[2] || (!bus.op[1] && bus.reg_in[2:0] == 3'd0);
      imm_data  = '0;
      imm_carry = 1'b0;
      case (bus.op)
         OP_ADD: begin
            imm_data  = add_full[W-1:0];
            imm_carry = add_full[W];
         end
         OP_SUB: begin
            imm_data  = sub_full[W-1:0];
            imm_carry = sub_full[W];
         end
         OP_AND:  imm_data = bus.acc_in & bus.reg_in;
         OP_XOR:  imm_data = bus.acc_in ^ bus.reg_in;
         OP_SHL,
         OP_SHR:  imm_data = bus.acc_in;
         default: imm_data = '0;
      endcase
   end

   // One iteration of the serial shifter and of the shift-add multiplier.
   always_comb begin
      shl_step = {a_reg[W-2:0], 1'b0};
      shr_step = {1'b0, a_reg[W-1:1]};
      mul_sum  = {1'b0, prod_reg[2*W-1:W]} + (prod_reg[0] ? {1'b0, a_reg} : {(W+1){1'b0}});
      mul_next = {mul_sum, prod_reg[W-1:1]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         op_reg    <= '0;
         dest_reg  <= '0;
         a_reg     <= '0;
         prod_reg  <= '0;
         cnt_reg   <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         we_reg    <= 1'b0;
         wnum_reg  <= '0;
         wdata_reg <= '0;
         carry_reg <= 1'b0;
      end else begin
         unique case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  op_reg   <= bus.op;
                  dest_reg <= bus.dest_in;
                  a_reg    <= bus.acc_in;
                  prod_reg <= {{W{1'b0}}, bus.reg_in};
                  busy_reg <= 1'b1;
                  if (imm_op) begin
                     state_reg <= DONE;
                     done_reg  <= 1'b1;
                     we_reg    <= 1'b1;
                     wnum_reg  <= bus.dest_in;
                     wdata_reg <= imm_data;
                     carry_reg <= imm_carry;
                  end else begin
                     state_reg <= RUN;
                     cnt_reg   <= bus.op[1] ? CW'(W) : CW'(bus.reg_in[2:0]);
                  end
               end
            end
            RUN: begin
               cnt_reg <= cnt_reg - CW'(1);
               case (op_reg)
                  OP_SHL:  a_reg    <= shl_step;
                  OP_SHR:  a_reg    <= shr_step;
                  default: prod_reg <= mul_next;
               endcase
               // Final iteration: publish the result directly so DONE carries it.
               if (cnt_reg == CW'(1)) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
                  we_reg    <= 1'b1;
                  wnum_reg  <= dest_reg;
                  case (op_reg)
                     OP_SHL: begin
                        wdata_reg <= shl_step;
                        carry_reg <= a_reg[W-1];
                     end
                     OP_SHR: begin
                        wdata_reg <= shr_step;
                        carry_reg <= a_reg[0];
                     end
                     OP_MUL: begin
                        wdata_reg <= mul_next[W-1:0];
                        carry_reg <= |mul_next[2*W-1:W];
                     end
                     default: begin
                        wdata_reg <= mul_next[2*W-1:W];
                        carry_reg <= 1'b0;
                     end
                  endcase
               end
            end
            DONE: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
               we_reg    <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
               we_reg    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy             = busy_reg;
   assign bus.done             = done_reg;
   assign bus.write_enabled    = we_reg;
   assign bus.reg_write_number = wnum_reg;
   assign bus.reg_write_data   = wdata_reg;
   assign bus.carry_out        = carry_reg;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed corner cases plus randomized operations,
// checked against an arithmetic reference model.
module tb_seq_alu;
   localparam int W = 8;
   localparam int D = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;

   typedef struct {
      logic [D-1:0] dest;
      logic [W-1:0] data;
      logic         carry;
      int           cyc;
   } exp_t;

   exp_t exp_q[$];

   seq_alu_if #(.W(W), .D(D)) bus ();
   seq_alu #(.W(W), .D(D)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint unsigned act, input longint unsigned req);
      checks++;
      if (act == req) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
   endtask

   // Reference model: plain integer arithmetic on the operands.
   function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [D-1:0] d, input int base);
      exp_t e;
      longint unsigned ai = a;
      longint unsigned bi = b;
      longint unsigned mask = (64'd1 << W) - 1;
      int n = int'(b[2:0]);
      longint unsigned r = 0;
      longint unsigned c = 0;
      int lat = 1;
      case (o)
         3'd0: begin r = ai + bi; c = r >> W; end
         3'd1: begin r = ai - bi; c = (ai < bi) ? 1 : 0; end
         3'd2: r = ai & bi;
         3'd3: r = ai ^ bi;
         3'd4: begin r = ai << n; c = (n > 0) ? ((ai >> (W - n)) & 1) : 0; lat = n + 1; end
         3'd5: begin r = ai >> n; c = (n > 0) ? ((ai >> (n - 1)) & 1) : 0; lat = n + 1; end
         3'd6: begin r = ai * bi; c = ((r >> W) != 0) ? 1 : 0; lat = W + 1; end
         default: begin r = (ai * bi) >> W; lat = W + 1; end
      endcase
      e.dest  = d;
      e.data  = W'(r & mask);
      e.carry = c[0];
      e.cyc   = base + lat;
      return e;
   endfunction

   // Monitor: every write-back must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && (bus.done || bus.write_enabled)) begin
         check("we_eq_done", bus.write_enabled, bus.done);
         if (exp_q.size() == 0) begin
            check("unexpected_write", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("done_cycle", cyc, e.cyc);
            check("busy_in_done", bus.busy, 1);
            check("reg_write_number", bus.reg_write_number, e.dest);
            check("reg_write_data", bus.reg_write_data, e.data);
            check("carry_out", bus.carry_out, e.carry);
            $display("write: dest=%0d data=0x%0h carry=%0d at cycle %0d",
                     bus.reg_write_number, bus.reg_write_data, bus.carry_out, cyc);
         end
      end
   end

   task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [D-1:0] d, input bit pulse);
      exp_t e;
      bit   finished = 0;
      @(negedge clk);
      bus.start   = 1'b1;
      bus.op      = o;
      bus.acc_in  = a;
      bus.reg_in  = b;
      bus.dest_in = d;
      e = model(o, a, b, d, cyc);
      exp_q.push_back(e);
      $display("issue: op=%0d a=0x%0h b=0x%0h dest=%0d pulse=%0d", o, a, b, d, pulse);
      @(negedge clk);
      for (int i = 0; i < 64; i++) begin
         if (!bus.busy) begin
            finished = 1;
            break;
         end
         bus.start  = pulse;
         bus.op     = 3'($urandom_range(7));
         bus.acc_in = W'($urandom);
         bus.reg_in = W'($urandom);
         @(negedge clk);
      end
      bus.start = 1'b0;
      if (!finished) check("op_timeout", 0, 1);
      check("hold_data", bus.reg_write_data, e.data);
      check("hold_carry", bus.carry_out, e.carry);
   endtask

   initial begin
      bus.start   = 1'b0;
      bus.op      = '0;
      bus.acc_in  = '0;
      bus.reg_in  = '0;
      bus.dest_in = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", bus.busy, 0);
      check("reset_we", bus.write_enabled, 0);
      check("reset_data", bus.reg_write_data, 0);
      reset = 1'b0;

      run_op(3'd0, 8'hF0, 8'h20, 4'd3, 0);
      run_op(3'd1, 8'h05, 8'h07, 4'd1, 0);
      run_op(3'd1, 8'h07, 8'h05, 4'd2, 0);
      run_op(3'd4, 8'h81, 8'h03, 4'd4, 0);
      run_op(3'd5, 8'h81, 8'h00, 4'd5, 0);
      run_op(3'd6, 8'h12, 8'h34, 4'd6, 0);
      run_op(3'd7, 8'h12, 8'h34, 4'd7, 0);
      run_op(3'd2, 8'hF3, 8'h3C, 4'd8, 0);
      run_op(3'd3, 8'hF3, 8'h3C, 4'd9, 0);
      run_op(3'd6, 8'hFF, 8'hFF, 4'd10, 1);
      run_op(3'd5, 8'h96, 8'h07, 4'd11, 1);

      // Reset in the fourth RUN cycle of a MUL: outputs clear at once, no write follows.
      @(negedge clk);
      bus.start  = 1'b1;
      bus.op     = 3'd6;
      bus.acc_in = 8'hAB;
      bus.reg_in = 8'hCD;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_we", bus.write_enabled, 0);
      check("rst_number", bus.reg_write_number, 0);
      check("rst_data", bus.reg_write_data, 0);
      check("rst_carry", bus.carry_out, 0);
      $display("reset asserted mid-MUL at cycle %0d", cyc);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (W + 4) @(negedge clk);
      check("no_resume", bus.busy, 0);
      run_op(3'd0, 8'h01, 8'h01, 4'd12, 0);

      for (int k = 0; k < 40; k++) begin
         run_op(3'($urandom_range(7)), W'($urandom), W'($urandom), D'($urandom), bit'($urandom_range(1)));
         repeat ($urandom_range(2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning the data width in bits.
REQ-002 The block SHALL have parameter D, default 4, meaning the register-number width (2**D registers).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-006 The block SHALL have port op, input, 3 bits: operation code per REQ-014.
REQ-007 The block SHALL have port acc_in, input, W bits: operand A, driven from the register file accumulator output.
REQ-008 The block SHALL have port reg_in, input, W bits: operand B, driven from the register file selected-register output.
REQ-009 The block SHALL have port dest_in, input, D bits: destination register number for the result.
REQ-010 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-011 The block SHALL have port done, output, 1 bit: high for exactly the one DONE cycle.
REQ-012 The block SHALL have port write_enabled, output, 1 bit, and port reg_write_number, output, D bits: register file write strobe and register number (the latched dest).
REQ-013 The block SHALL have port reg_write_data, output, W bits, and port carry_out, output, 1 bit: result and carry/flag.

Function
REQ-014 op encoding SHALL be 000 ADD A+B; 001 SUB A-B; 010 AND; 011 XOR; 100 SHL A by B[2:0]; 101 SHR (logical) A by B[2:0]; 110 MUL low W bits of A*B; 111 MULH high W bits of A*B (unsigned).
REQ-015 The FSM SHALL have exactly three states, IDLE, RUN and DONE, with IDLE as the reset state.
REQ-016 In IDLE with start=1, the block SHALL latch A, B, op and dest on that edge; start while busy=1 SHALL be ignored with no effect.
REQ-017 ADD, SUB, AND, XOR, and SHL/SHR with B[2:0]=0, SHALL go IDLE->DONE, so done asserts 1 cycle after the start edge.
REQ-018 SHL/SHR with count N=B[2:0]>0 SHALL go IDLE->RUN, shift one bit per cycle for N cycles, then go to DONE, so done asserts N+1 cycles after start.
REQ-019 MUL/MULH SHALL use an iterative shift-add over exactly W RUN cycles with a 2W-bit product register, then go to DONE, so done asserts W+1 cycles after start.
REQ-020 DONE SHALL last exactly one cycle and always return to IDLE; a start in the DONE cycle SHALL be ignored.
REQ-021 In DONE, write_enabled SHALL be 1, and reg_write_number and reg_write_data SHALL be valid; write_enabled SHALL be 0 in all other states.
REQ-022 reg_write_data and carry_out SHALL hold their last DONE values until the next DONE.
REQ-023 For ADD, carry_out SHALL be the carry out of bit W-1.
REQ-024 For SUB, carry_out SHALL be 1 when A<B unsigned (borrow), and the result SHALL wrap modulo 2**W.
REQ-025 For AND and XOR, carry_out SHALL be 0.
REQ-026 For SHL/SHR, carry_out SHALL be the last bit shifted out, or 0 when N=0.
REQ-027 For MUL, carry_out SHALL be 1 when the high W bits are nonzero; for MULH, carry_out SHALL be 0.
REQ-028 Operand inputs changing after the start edge SHALL NOT affect the result.
REQ-029 All result arithmetic SHALL truncate to W bits, with no sign extension.

Reset
REQ-030 Asserting reset at any time, including mid-RUN, SHALL immediately force IDLE, with busy=0, done=0, write_enabled=0, reg_write_number=0, reg_write_data=0 and carry_out=0.
REQ-031 An operation interrupted by reset SHALL produce no write and SHALL NOT resume after reset deasserts.
REQ-032 The first start sampled after reset deasserts SHALL be handled normally.

Verification
REQ-033 The bench SHALL cover: ADD A=0xF0, B=0x20, dest=3 -> one cycle later done=1, write_enabled=1, reg_write_number=3, reg_write_data=0x10, carry_out=1.
REQ-034 The bench SHALL cover: SUB A=0x05, B=0x07 -> reg_write_data=0xFE, carry_out=1; and SUB A=0x07, B=0x05 -> 0x02, carry_out=0.
REQ-035 The bench SHALL cover: SHL A=0x81, B=0x03 -> done at start+4 cycles, reg_write_data=0x08, carry_out=0; and SHR A=0x81, B=0x00 -> done at start+1, 0x81, carry_out=0.
REQ-036 The bench SHALL cover: MUL A=0x12, B=0x34 -> done at start+9, reg_write_data=0xA8, carry_out=1; and MULH with the same operands -> 0x03, carry_out=0.
REQ-037 The bench SHALL cover: start pulsed during RUN and in the DONE cycle of a MUL -> ignored, exactly one write per accepted start.
REQ-038 The bench SHALL cover: reset asserted at RUN cycle 4 of a MUL -> all outputs 0 immediately, no write_enabled pulse; then a new ADD 1+1 -> 0x02.
